spm_serial_ctrl: RTL
====================

Name: spm_serial_ctrl

Overview:
Sequencing wrapper that sits directly around the serial-parallel multiplier CSA array.
- Upstream: accepts a signed multiplicand/multiplier pair over a valid/ready handshake.
- Toward the array: holds the multiplicand on the parallel x bus, serialises the multiplier LSB-first (sign-extended) onto the y bit that feeds every csa hsum stage.
- From the array: deserialises the returned product bit stream into a 2*WIDTH-bit result, offered downstream over valid/ready.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH.
CORE_LAT, 1, cycles from a y bit driven to the matching product bit on core_p.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  operand pair valid.
in_ready  out  1  block can accept operands.
in_a  in  WIDTH  signed multiplicand (parallel x).
in_b  in  WIDTH  signed multiplier (serialised to y).
core_clr  out  1  synchronous clear pulse to CSA sum/carry registers.
core_x  out  WIDTH  multiplicand held to array.
core_y  out  1  serial multiplier bit.
core_p  in  1  serial product bit from array.
out_valid  out  1  product valid.
out_ready  in  1  downstream accepts product.
out_p  out  2*WIDTH  signed product.

Behaviour:
- Reset values: state=IDLE; in_ready=1; out_valid=0; core_clr=0; core_x=0; core_y=0; out_p=0; bit counter=0.
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: register a_reg=in_a and b_sh=in_b, then go to CLEAR.
- CLEAR (1 cycle):
  - in_ready=0; core_clr=1; core_x=a_reg.
  - Go to RUN with count=0.
- RUN (exactly 2*WIDTH+CORE_LAT cycles):
  - core_x holds a_reg, stable for the whole state.
  - core_y=b_sh[0] each cycle, then b_sh shifts right arithmetically. After WIDTH cycles y therefore repeats the sign bit.
  - When count >= CORE_LAT: shift core_p into the MSB of the product shift register (right shift), so the first captured bit ends as out_p[0].
  - After count = 2*WIDTH+CORE_LAT-1, go to DONE.
- DONE:
  - out_valid=1; out_p is stable.
  - Hold until out_ready, then go to IDLE. in_ready rises the cycle after the handshake.
- in_ready=0 in CLEAR, RUN and DONE. There is no overlap of operations.
- Latency: accept in cycle 0, out_valid in cycle 2+2*WIDTH+CORE_LAT (WIDTH=8, CORE_LAT=1: cycle 19).
- Product is the exact two's-complement result mod 2^(2*WIDTH). The most-negative × most-negative case is representable and needs no saturation.
- out_valid and out_p must not change while out_valid=1 and out_ready=0.
- out_ready while not in DONE is ignored. in_valid while in_ready=0 is ignored, and operands are not sampled.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values. The pending product is discarded, and the next operation starts with a CLEAR.
- Counter width: $clog2(2*WIDTH+CORE_LAT+1). The counter must not wrap within one operation.

Optional Feature:
SPM_CTRL_ZERO_SKIP_EN.
- Defined: in IDLE, if in_a==0 or in_b==0 at acceptance, go directly to DONE with out_p=0.
  - out_valid is asserted in cycle 1.
  - No core_clr pulse, no RUN, core_y stays 0.
- Undefined: every operation takes the full CLEAR+RUN path.

Decomposition:
- Package spm_ctrl_pkg:
  - state enum (IDLE, CLEAR, RUN, DONE).
  - function returning the counter width from WIDTH/CORE_LAT.
  - localparam for the default CORE_LAT.
- One sub-module, spm_prod_deser:
  - 2*WIDTH-bit right-shifting capture register.
  - Inputs: clr, shift_en, bit_in.
  - Output: the parallel word.
  - The FSM and the y serialiser stay in the top.

Test Plan:
- WIDTH=8, in_a=3, in_b=5, core model = behavioural spm with CORE_LAT=1 -> out_p=16'h000F, out_valid first high in cycle 19, core_clr high only in cycle 1.
- in_a=-3 (8'hFD), in_b=5 -> out_p=16'hFFF1; in_a=5, in_b=-3 -> 16'hFFF1. Check core_y = 1,0,1,1,1,1,1,1 then eight 1s for in_b=8'hFD.
- in_a=in_b=8'h80 -> out_p=16'h4000; in_a=in_b=8'h7F -> 16'h3F01.
- Back-pressure: out_ready low 5 cycles after out_valid -> out_p/out_valid unchanged, in_ready=0 and new in_valid ignored. out_ready high -> in_ready=1 next cycle, next operand pair accepted.
- Reset pulse at RUN count 7 -> all outputs at reset values within the same cycle. Following 3*5 operation -> 16'h000F, unaffected by stale data.
- SPM_CTRL_ZERO_SKIP_EN defined: in_a=0, in_b=8'h55 -> out_valid in cycle 1, out_p=0, core_clr never asserted. Undefined: same stimulus -> out_p=0 in cycle 19.

Source files
------------

// File: rtl/spm_ctrl_pkg.sv
// Shared types and helpers for the serial-parallel multiplier controller.
//   state_t          : controller FSM states (IDLE, CLEAR, RUN, DONE)
//   CORE_LAT_DEFAULT : default array latency, y bit in -> product bit out
//   cnt_width()      : width of the RUN bit counter for a WIDTH/CORE_LAT pair
package spm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CORE_LAT_DEFAULT = 1;

  // The counter must reach 2*width+core_lat-1 without wrapping. The
  // extra +1 leaves headroom so the terminal value never aliases zero.
  function automatic int cnt_width(input int width, input int core_lat);
    return $clog2(2 * width + core_lat + 1);
  endfunction

endpackage

// File: rtl/spm_serial_ctrl_if.sv
// Bus bundle between the controller, its upstream/downstream users and
// the CSA array.
//   in_valid/in_ready/in_a/in_b  : operand pair handshake
//   core_clr/core_x/core_y       : drive toward the CSA array
//   core_p                       : serial product bit from the array
//   out_valid/out_ready/out_p    : product handshake
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high; the producer keeps valid and data
// stable until that edge, and ready may be anything while valid is low.
// Modports: slave = the controller, master = its environment.
interface spm_serial_ctrl_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               core_clr;
  logic [WIDTH-1:0]   core_x;
  logic               core_y;
  logic               core_p;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;

  modport master (
    output in_valid, in_a, in_b, core_p, out_ready,
    input  in_ready, core_clr, core_x, core_y, out_valid, out_p
  );

  modport slave (
    input  in_valid, in_a, in_b, core_p, out_ready,
    output in_ready, core_clr, core_x, core_y, out_valid, out_p
  );
endinterface

// File: rtl/spm_prod_deser.sv
// Product deserialiser: a 2*WIDTH-bit right-shifting capture register.
// Bits enter at the MSB, so after 2*WIDTH shifts the first captured bit
// sits in word[0].
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : synchronous clear to zero (wins over shift_en)
//   shift_en  : shift bit_in into the MSB this cycle
//   bit_in    : serial product bit
//   word      : parallel product
module spm_prod_deser #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift_en,
  input  logic               bit_in,
  output logic [2*WIDTH-1:0] word
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
    end else if (clr) begin
      word <= '0;
    end else if (shift_en) begin
      word <= {bit_in, word[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/spm_serial_ctrl.sv
// Sequencing wrapper around the serial-parallel multiplier CSA array.
// Accepts a signed operand pair, clears the array, holds the multiplicand
// on core_x, streams the sign-extended multiplier LSB-first on core_y for
// 2*WIDTH+CORE_LAT cycles, collects the returned product bits and offers
// the 2*WIDTH-bit product downstream. One operation at a time.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : spm_serial_ctrl_if.slave (operand, array and product signals)
//   state_dbg  : current FSM state
// Optional build macro SPM_CTRL_ZERO_SKIP_EN: a zero operand at acceptance
// bypasses CLEAR/RUN and completes in DONE with a zero product.
module spm_serial_ctrl
  import spm_ctrl_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CORE_LAT = CORE_LAT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  spm_serial_ctrl_if.slave    bus,
  output state_t              state_dbg
);

  localparam int            CW       = cnt_width(WIDTH, CORE_LAT);
  localparam logic [CW-1:0] LAST_CNT = CW'(2 * WIDTH + CORE_LAT - 1);
  localparam logic [CW-1:0] LAT_CNT  = CW'(CORE_LAT);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_sh;
  logic [CW-1:0]      cnt_q;
  logic               accept;
  logic               skip;
  logic               deser_clr;
  logic               deser_shift;
  logic [2*WIDTH-1:0] prod;

  assign accept = (state_q == IDLE) && bus.in_valid;

`ifdef SPM_CTRL_ZERO_SKIP_EN
  assign skip = (bus.in_a == '0) || (bus.in_b == '0);
`else
  assign skip = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and array/handshake outputs
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.core_clr  = 1'b0;
    bus.core_y    = 1'b0;
    bus.out_valid = 1'b0;
    deser_clr     = 1'b0;
    deser_shift   = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          // A skipped operation still clears the capture register so
          // DONE presents a zero product.
          state_d   = skip ? DONE : CLEAR;
          deser_clr = skip;
        end
      end
      CLEAR: begin
        bus.core_clr = 1'b1;
        deser_clr    = 1'b1;
        state_d      = RUN;
      end
      RUN: begin
        bus.core_y = b_sh[0];
        // The first CORE_LAT bits on core_p belong to no y bit yet.
        deser_shift = (cnt_q >= LAT_CNT);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand registers and the RUN bit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_sh  <= '0;
      cnt_q <= '0;
    end else begin
      if (accept) begin
        a_reg <= bus.in_a;
        b_sh  <= bus.in_b;
      end else if (state_q == CLEAR) begin
        cnt_q <= '0;
      end else if (state_q == RUN) begin
        // Arithmetic shift: once the WIDTH real bits are out, y keeps
        // repeating the sign bit, which is the sign extension the array
        // needs for the upper half of the product.
        b_sh  <= {b_sh[WIDTH-1], b_sh[WIDTH-1:1]};
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  spm_prod_deser #(
    .WIDTH (WIDTH)
  ) u_deser (
    .clk      (clk),
    .rst      (rst),
    .clr      (deser_clr),
    .shift_en (deser_shift),
    .bit_in   (bus.core_p),
    .word     (prod)
  );

  assign bus.core_x = a_reg;
  assign bus.out_p  = prod;
  assign state_dbg  = state_q;

endmodule
